// File: rtl/timer_prescaler.sv
// timer_prescaler: multi-channel counter-enable tick generator (pow2/linear divide).
// Define TMR_PSC_HALT_EN to let dbg_halt freeze the prescale counters.
module timer_prescaler #(
    parameter int NUM_CH  = 2,
    parameter int DIV_W   = 4,
    parameter int MAX_DIV = 8,
    parameter int CNT_W   = 8
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NUM_CH-1:0]       timer_en,
    input  logic [NUM_CH-1:0]       div_en,
    input  logic [NUM_CH-1:0]       div_mode,
    input  logic [NUM_CH*DIV_W-1:0] div_val,
    input  logic                    dbg_halt,
    output logic [NUM_CH-1:0]       count_en,
    output logic [NUM_CH-1:0]       div_err,
    output logic [NUM_CH*CNT_W-1:0] cnt_o
);

    logic halt_req;

`ifdef TMR_PSC_HALT_EN
    assign halt_req = dbg_halt;
`else
    logic halt_unused;
    assign halt_unused = dbg_halt;
    assign halt_req    = 1'b0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] val, sh_val;
        logic             sh_mode;
        logic [CNT_W-1:0] cnt, cnt_max, cnt_nxt;
        logic             legal, chg, halt, at_max, restart;

        assign val     = div_val[c*DIV_W +: DIV_W];
        assign legal   = div_mode[c] | (32'(val) <= MAX_DIV);
        assign cnt_max = div_mode[c] ? CNT_W'(val) : (CNT_W'(1) << val) - CNT_W'(1);
        assign chg     = (val != sh_val) | (div_mode[c] != sh_mode);
        assign halt    = halt_req & timer_en[c];
        assign at_max  = cnt == cnt_max;
        assign restart = ~timer_en[c] | ~div_en[c] | ~legal | chg;

        // restart beats halt, halt beats wrap, otherwise advance
        always_comb cnt_nxt = restart ? '0 : halt ? cnt : at_max ? '0 : cnt + 1'b1;

        // prescale counter and config shadows used for change detection
        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt     <= '0;
                sh_val  <= '0;
                sh_mode <= 1'b0;
            end else begin
                cnt     <= cnt_nxt;
                sh_val  <= val;
                sh_mode <= div_mode[c];
            end
        end

        assign count_en[c] = sys_rst_n & timer_en[c] & ~halt &
                             (~div_en[c] | (legal & ~chg & at_max));
        assign div_err[c]  = sys_rst_n & timer_en[c] & div_en[c] & ~legal;
        assign cnt_o[c*CNT_W +: CNT_W] = cnt;
    end

endmodule

// File: tb/tb_timer_prescaler.sv
// tb_timer_prescaler: directed plus randomized check of timer_prescaler against a period/modulo model.
module tb_timer_prescaler;
    localparam int NUM_CH = 2, DIV_W = 4, MAX_DIV = 8, CNT_W = 8;

    logic                    sys_clk = 1'b0, sys_rst_n = 1'b0, dbg_halt = 1'b0;
    logic [NUM_CH-1:0]       timer_en = '0, div_en = '0, div_mode = '0;
    logic [NUM_CH*DIV_W-1:0] div_val = '0;
    logic [NUM_CH-1:0]       count_en, div_err;
    logic [NUM_CH*CNT_W-1:0] cnt_o;

    int n_checks = 0, n_errors = 0, cyc = 0, base = 0;
    int elapsed[NUM_CH], pval[NUM_CH], pmode[NUM_CH];
    int ticks0[$];

    timer_prescaler #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .MAX_DIV(MAX_DIV), .CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .timer_en(timer_en), .div_en(div_en),
        .div_mode(div_mode), .div_val(div_val), .dbg_halt(dbg_halt),
        .count_en(count_en), .div_err(div_err), .cnt_o(cnt_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int mx(int mode, int v);
        return mode != 0 ? v : (1 << v) - 1;
    endfunction

    function automatic bit lg(int mode, int v);
        return mode != 0 || v <= MAX_DIV;
    endfunction

    function automatic bit hlt_of(int c);
        bit h = 1'b0;
`ifdef TMR_PSC_HALT_EN
        h = dbg_halt && timer_en[c];
`endif
        return h;
    endfunction

    // Called just after a falling edge with inputs applied; checks, then advances one clock.
    task automatic step();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            int v = int'(div_val[c*DIV_W +: DIV_W]);
            int m = int'(div_mode[c]);
            bit chg = v != pval[c] || m != pmode[c];
            int ecnt = elapsed[c] % (mx(pmode[c], pval[c]) + 1);
            bit err = timer_en[c] && div_en[c] && !lg(m, v);
            bit tick = timer_en[c] && !hlt_of(c) &&
                       (!div_en[c] || (lg(m, v) && !chg && ecnt == mx(m, v)));
            if (!sys_rst_n) begin
                ecnt = 0;
                err  = 0;
                tick = 0;
            end
            chk($sformatf("count_en%0d", c), count_en[c], tick);
            chk($sformatf("div_err%0d", c), div_err[c], err);
            chk($sformatf("cnt_o%0d", c), cnt_o[c*CNT_W +: CNT_W], ecnt);
        end
        if (count_en[0]) ticks0.push_back(cyc - base);
        @(posedge sys_clk);
        for (int c = 0; c < NUM_CH; c++) begin
            int v = int'(div_val[c*DIV_W +: DIV_W]);
            int m = int'(div_mode[c]);
            if (!sys_rst_n) begin
                elapsed[c] = 0;
                pval[c]    = 0;
                pmode[c]   = 0;
            end else begin
                if (!timer_en[c] || !div_en[c] || !lg(m, v) || v != pval[c] || m != pmode[c])
                    elapsed[c] = 0;
                else if (!hlt_of(c))
                    elapsed[c]++;
                pval[c]  = v;
                pmode[c] = m;
            end
        end
        cyc++;
        @(negedge sys_clk);
    endtask

    task automatic wait_cnt0(input int target);
        int k = 0;
        while (int'(cnt_o[CNT_W-1:0]) != target && k < 300) begin
            step();
            k++;
        end
        chk("wait_cnt0", cnt_o[CNT_W-1:0], target);
    endtask

    initial begin
        for (int c = 0; c < NUM_CH; c++) begin
            elapsed[c] = 0;
            pval[c]    = 0;
            pmode[c]   = 0;
        end
        @(negedge sys_clk);
        timer_en = '1;
        div_val  = {4'd9, 4'd9};
        repeat (3) step();
        sys_rst_n = 1'b1;
        timer_en  = 2'b01;
        div_val   = '0;
        repeat (5) step();

        timer_en = 2'b00;
        div_en   = 2'b01;
        div_val[3:0] = 4'd3;
        step();
        timer_en = 2'b01;
        base = cyc;
        ticks0.delete();
        repeat (24) step();
        chk("ticks_n", ticks0.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("tick_at", i < ticks0.size() ? ticks0[i] : -1, 7 + 8 * i);

        timer_en = 2'b11;
        div_en   = 2'b11;
        div_mode = 2'b10;
        div_val  = {4'd4, 4'd2};
        repeat (40) step();

        div_val[3:0] = 4'd9;
        repeat (5) step();
        chk("div_err_ill", div_err[0], 1);
        chk("cnt_ill", cnt_o[CNT_W-1:0], 0);
        div_val[3:0] = 4'd1;
        repeat (10) step();

        div_val[3:0] = 4'd3;
        wait_cnt0(6);
        div_val[3:0] = 4'd5;
        step();
        chk("cnt_after_chg", cnt_o[CNT_W-1:0], 0);
        base = cyc;
        ticks0.delete();
        repeat (40) step();
        chk("chg_tick", ticks0.size() > 0 ? ticks0[0] : -1, 31);

        div_val[3:0] = 4'd3;
        wait_cnt0(4);
        dbg_halt = 1'b1;
        repeat (10) step();
`ifdef TMR_PSC_HALT_EN
        chk("halt_cnt", cnt_o[CNT_W-1:0], 4);
`endif
        dbg_halt = 1'b0;
        repeat (12) step();

        wait_cnt0(5);
        sys_rst_n = 1'b0;
        step();
        chk("async_rst_cnt", cnt_o[CNT_W-1:0], 0);
        sys_rst_n = 1'b1;
        repeat (20) step();

        repeat (3000) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    div_val[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 3) == 0 ?
                                                $urandom_range(0, 15) : $urandom_range(0, 4));
                    div_mode[c] = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 39) == 0) timer_en[c] = ~timer_en[c];
                if ($urandom_range(0, 39) == 0) div_en[c] = ~div_en[c];
            end
            if ($urandom_range(0, 14) == 0) dbg_halt = ~dbg_halt;
            sys_rst_n = $urandom_range(0, 499) != 0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
